da_csa_acc: RTL
===============

DA_CSA_ACC -- requirements
Module: da_csa_acc

Interface
REQ-001 SHALL have parameter IW, default 10, width of each signed addend.
REQ-002 SHALL have parameter B, default 8, addend words per operation (input sample bit count), B >= 2.
REQ-003 SHALL have derived localparam AW = IW+B+2, accumulator width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port r  input  1  synchronous active-high reset.
REQ-006 SHALL have port start  input  1  begin operation; honoured only when busy=0.
REQ-007 SHALL have port init  input  AW  offset loaded on accepted start.
REQ-008 SHALL have port in_valid  input  1  a1/a2 valid this cycle.
REQ-009 SHALL have port a1, a2  input  IW each  signed two's-complement addends.
REQ-010 SHALL have port in_ready  output  1  high while accepting addends.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port sum, carry  output  AW each  carry-save result pair.
REQ-013 SHALL have port out_valid  output  1  one-cycle result strobe.

Function
REQ-014 SHALL implement FSM IDLE -> ACC -> DONE -> IDLE.
REQ-015 IDLE: start=1 loads sum=init, carry=0, count=0, next state ACC; no addend consumed that cycle.
REQ-016 in_ready SHALL equal (state==ACC); an addend word is accepted on an edge with in_ready & in_valid.
REQ-017 Each accept SHALL update sum/carry = 2*(sum+carry) + sext(a1) + sext(a2), using two 3:2 carry-save layers; no carry-propagate adder in the loop.
REQ-018 First accepted word (count=0, sign bit) SHALL be negated: a1, a2 inverted, +1 injected into the free LSB of each layer's carry vector.
REQ-019 ACC with in_valid=0 SHALL hold sum, carry and count unchanged (stall); there is no stall limit.
REQ-020 After the B-th accept, state SHALL go to DONE; in DONE out_valid=1 for exactly one cycle, then IDLE.
REQ-021 Result: (sum+carry) mod 2^AW = init*2^B - (a1_0+a2_0)*2^(B-1) + sum over k=1..B-1 of (a1_k+a2_k)*2^(B-1-k), where k is the accept index.
REQ-022 All arithmetic SHALL be modulo 2^AW; bits shifted out of the MSB are discarded.
REQ-023 sum/carry SHALL hold their final value in DONE and IDLE until the next accepted start.
REQ-024 start while busy=1 SHALL be ignored, with no effect on state or data.
REQ-025 Minimum latency: start accepted at edge t; with in_valid held high, out_valid=1 in the cycle following edge t+B+1.
REQ-026 start in the same cycle that out_valid=1 SHALL be ignored (state is DONE); a new start is accepted from IDLE one cycle later.

Reset
REQ-027 r=1 at an edge SHALL force state=IDLE, count=0, sum=0, carry=0, out_valid=0, in_ready=0, busy=0, overriding start/in_valid.
REQ-028 r=1 mid-ACC or in DONE SHALL abort the operation; no out_valid is produced for the aborted operation.

Configuration
REQ-029 Macro DA_CSA_RESOLVE_EN: when defined, the block SHALL add output res (AW bits) = sum+carry, registered, and delay out_valid by one cycle so it aligns with res; latency +1; reset value of res = 0.
REQ-030 Without DA_CSA_RESOLVE_EN, port res SHALL be absent and timing SHALL be as in REQ-025.

Verification (IW=10, B=8, AW=20, macro undefined unless stated)
REQ-031 init=0, a1=a2=10'h3FF for all 8 words, in_valid held high -> out_valid 10 cycles after start edge; (sum+carry) mod 2^20 = 2.
REQ-032 init=0, word0 a1=1/a2=0, words 1..7 zero -> (sum+carry) mod 2^20 = 20'hFFF80 (-128).
REQ-033 init=5, all addends zero -> (sum+carry) = 1280; with DA_CSA_RESOLVE_EN, res=1280 and out_valid one cycle later.
REQ-034 REQ-031 stimulus with in_valid low for 3 cycles after word 4 -> same result, out_valid delayed by exactly 3 cycles.
REQ-035 r=1 after word 5 -> next cycle state IDLE, sum=carry=0, busy=0, and no out_valid; a subsequent clean run gives the correct result.
REQ-036 start pulsed during ACC and during DONE -> ignored; the result of the running operation is unchanged.

Source files
------------

// File: rtl/da_csa_acc.sv
// da_csa_acc: distributed-arithmetic style shift-accumulate of two signed
// addend streams, kept in carry-save form (sum/carry) so the per-word loop
// contains no carry-propagate adder. One operation takes B addend words; the
// first word carries the sign weight and is subtracted.
//
// Optional feature macro: DA_CSA_RESOLVE_EN
//   defined   -> adds registered output res = sum + carry and delays
//                out_valid by one cycle to line up with it.
//   undefined -> res is absent; out_valid comes straight from the FSM.
module da_csa_acc #(
    parameter  int IW = 10,
    parameter  int B  = 8,
    localparam int AW = IW + B + 2
) (
    input  logic          clk,
    input  logic          r,
    input  logic          start,
    input  logic [AW-1:0] init,
    input  logic          in_valid,
    input  logic [IW-1:0] a1,
    input  logic [IW-1:0] a2,
    output logic          in_ready,
    output logic          busy,
    output logic [AW-1:0] sum,
    output logic [AW-1:0] carry,
    output logic          out_valid
`ifdef DA_CSA_RESOLVE_EN
    ,
    output logic [AW-1:0] res
`endif
);

    localparam int CW = $clog2(B + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] sum_q,   sum_d;
    logic [AW-1:0] carry_q, carry_d;
    logic          ov_q,    ov_d;

    logic          neg;
    logic [AW-1:0] x1, x2;
    logic [AW-1:0] s2, c2;
    logic [AW-1:0] maj1, maj2;
    logic [AW-1:0] l1_s, l1_c;
    logic [AW-1:0] l2_s, l2_c;

    // Two 3:2 carry-save layers computing 2*(sum+carry) + x1 + x2; on the
    // sign word the addends are inverted and the +1 of each two's-complement
    // negation rides in the empty LSB of that layer's shifted carry vector.
    always_comb begin
        neg  = (count_q == '0);
        x1   = {{(AW-IW){a1[IW-1]}}, a1};
        x2   = {{(AW-IW){a2[IW-1]}}, a2};
        if (neg) begin
            x1 = ~x1;
            x2 = ~x2;
        end
        s2   = sum_q << 1;
        c2   = carry_q << 1;
        l1_s = s2 ^ c2 ^ x1;
        maj1 = (s2 & c2) | (s2 & x1) | (c2 & x1);
        l1_c = (maj1 << 1) | {{(AW-1){1'b0}}, neg};
        l2_s = l1_s ^ l1_c ^ x2;
        maj2 = (l1_s & l1_c) | (l1_s & x2) | (l1_c & x2);
        l2_c = (maj2 << 1) | {{(AW-1){1'b0}}, neg};
    end

    // Control FSM and next-state selection for the carry-save registers.
    // DONE lasts two cycles: the first arms out_valid, the second shows it,
    // so the strobe is registered yet still appears while busy is high.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ov_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACC;
                    sum_d   = init;
                    carry_d = '0;
                    count_d = '0;
                end
            end
            S_ACC: begin
                if (in_valid) begin
                    sum_d   = l2_s;
                    carry_d = l2_c;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(B - 1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!ov_q) begin
                    ov_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset that aborts any operation.
    always_ff @(posedge clk) begin
        if (r) begin
            state_q <= S_IDLE;
            count_q <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ov_q    <= ov_d;
        end
    end

    assign in_ready = (state_q == S_ACC);
    assign busy     = (state_q != S_IDLE);
    assign sum      = sum_q;
    assign carry    = carry_q;

`ifdef DA_CSA_RESOLVE_EN
    logic [AW-1:0] res_q;
    logic          ovd_q;

    // Resolve the carry-save pair and delay the strobe to match it.
    always_ff @(posedge clk) begin
        if (r) begin
            res_q <= '0;
            ovd_q <= 1'b0;
        end else begin
            res_q <= sum_q + carry_q;
            ovd_q <= ov_q;
        end
    end

    assign res       = res_q;
    assign out_valid = ovd_q;
`else
    assign out_valid = ov_q;
`endif

endmodule
